// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: opcodes, functs,
// FSM state codes and datapath select codes.
package mips_mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_RTYPE_EX = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_IMM_EX   = 4'd10,
        S_IMM_WB   = 4'd11,
        S_FAULT    = 4'd15
    } state_e;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        SRCB_B      = 2'b00,
        SRCB_FOUR   = 2'b01,
        SRCB_IMM    = 2'b10,
        SRCB_IMM_SH = 2'b11
    } srcb_e;

    typedef enum logic [1:0] {
        PCS_ALU    = 2'b00,
        PCS_ALUOUT = 2'b01,
        PCS_JUMP   = 2'b10
    } pcsrc_e;

endpackage

// File: rtl/mips_alu_decoder.sv
// Combinational ALU operation decode: R-type funct or I-type opcode to
// ALUControl/ExtOp, with an illegal flag for unsupported encodings.
module mips_alu_decoder
    import mips_mc_pkg::*;
#(
    parameter int unsigned ENABLE_IMM = 1
) (
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output logic [2:0] alu_ctrl_o,
    output logic       ext_op_o,
    output logic       illegal_o
);

    always_comb begin
        alu_ctrl_o = ALU_ADD;
        ext_op_o   = 1'b0;
        illegal_o  = 1'b0;
        if (opcode_i == OP_RTYPE) begin
            case (funct_i)
                FN_ADD:  alu_ctrl_o = ALU_ADD;
                FN_SUB:  alu_ctrl_o = ALU_SUB;
                FN_AND:  alu_ctrl_o = ALU_AND;
                FN_OR:   alu_ctrl_o = ALU_OR;
                FN_SLT:  alu_ctrl_o = ALU_SLT;
                default: illegal_o  = 1'b1;
            endcase
        end else if (ENABLE_IMM != 0) begin
            // Logical immediates zero-extend; arithmetic ones sign-extend.
            case (opcode_i)
                OP_ADDI: alu_ctrl_o = ALU_ADD;
                OP_SLTI: alu_ctrl_o = ALU_SLT;
                OP_ANDI: begin
                    alu_ctrl_o = ALU_AND;
                    ext_op_o   = 1'b1;
                end
                OP_ORI: begin
                    alu_ctrl_o = ALU_OR;
                    ext_op_o   = 1'b1;
                end
                default: illegal_o = 1'b1;
            endcase
        end else begin
            illegal_o = 1'b1;
        end
    end

endmodule

// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS control FSM with memory-ready handshake, memory watchdog
// and sticky fault state.
module mips_mc_control
    import mips_mc_pkg::*;
#(
    parameter int unsigned ENABLE_IMM  = 1,
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned TO_W        = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic       ExtOp,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [2:0] ALUControl,
    output logic       pc_en,
    output logic       fault,
    output logic [3:0] state
);

    localparam logic [TO_W-1:0] WD_LIMIT = TO_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

    state_e          state_q, state_d;
    logic [TO_W-1:0] wd_q, wd_d;

    logic [2:0] dec_alu;
    logic       dec_ext;
    logic       dec_illegal;
    logic       mem_state;
    logic       wd_expire;
    logic       branch_ne;

    logic pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write;

    mips_alu_decoder #(
        .ENABLE_IMM(ENABLE_IMM)
    ) u_alu_dec (
        .opcode_i  (opcode),
        .funct_i   (funct),
        .alu_ctrl_o(dec_alu),
        .ext_op_o  (dec_ext),
        .illegal_o (dec_illegal)
    );

    assign mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    assign wd_expire = (MEM_TIMEOUT != 0) && mem_state && !mem_ready && (wd_q == WD_LIMIT);
    assign branch_ne = (opcode == OP_BNE);

    always_comb begin
        state_d       = state_q;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        IorD          = 1'b0;
        RegDst        = 1'b0;
        MemtoReg      = 1'b0;
        ALUSrcA       = 1'b0;
        ExtOp         = 1'b0;
        ALUSrcB       = SRCB_B;
        PCSource      = PCS_ALU;
        ALUControl    = ALU_ADD;

        case (state_q)
            S_FETCH: begin
                mem_read = 1'b1;
                ALUSrcB  = SRCB_FOUR;
                ir_write = mem_ready;
                pc_write = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcB = SRCB_IMM_SH;
                case (opcode)
                    OP_RTYPE:                         state_d = S_RTYPE_EX;
                    OP_LW, OP_SW:                     state_d = S_MEMADR;
                    OP_BEQ, OP_BNE:                   state_d = S_BRANCH;
                    OP_J:                             state_d = S_JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI:
                        state_d = (ENABLE_IMM != 0) ? S_IMM_EX : S_FAULT;
                    default:                          state_d = S_FAULT;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                IorD     = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                MemtoReg  = 1'b1;
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                IorD      = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_RTYPE_EX: begin
                ALUSrcA    = 1'b1;
                ALUControl = dec_alu;
                state_d    = dec_illegal ? S_FAULT : S_ALUWB;
            end
            S_ALUWB: begin
                RegDst    = 1'b1;
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA       = 1'b1;
                ALUControl    = ALU_SUB;
                PCSource      = PCS_ALUOUT;
                pc_write_cond = 1'b1;
                state_d       = S_FETCH;
            end
            S_JUMP: begin
                PCSource = PCS_JUMP;
                pc_write = 1'b1;
                state_d  = S_FETCH;
            end
            S_IMM_EX: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_IMM;
                ALUControl = dec_alu;
                ExtOp      = dec_ext;
                state_d    = S_IMM_WB;
            end
            S_IMM_WB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_FAULT;
        endcase

        // A late ready on the limit cycle keeps wd_expire low, so the access completes.
        if (wd_expire) state_d = S_FAULT;
    end

    always_comb begin
        wd_d = wd_q;
        if (state_d != state_q) begin
            wd_d = '0;
        end else if (mem_state && !mem_ready) begin
            wd_d = wd_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
        end
    end

    // Strobes are masked by the reset level so an aborted access never leaks out.
    assign PCWrite     = reset & pc_write;
    assign PCWriteCond = reset & pc_write_cond;
    assign MemRead     = reset & mem_read;
    assign MemWrite    = reset & mem_write;
    assign IRWrite     = reset & ir_write;
    assign RegWrite    = reset & reg_write;
    assign pc_en       = reset & (pc_write | (pc_write_cond & (zero ^ branch_ne)));
    assign fault       = (state_q == S_FAULT);
    assign state       = state_q;

endmodule

// File: tb/tb_mips_mc_control.sv
// Directed bench for mips_mc_control: a default instance (imm enabled, long
// timeout) and a second one with imm disabled and a 4-cycle watchdog.
module tb_mips_mc_control;

    localparam logic [5:0] RT   = 6'b000000;
    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] BNE  = 6'b000101;
    localparam logic [5:0] JMP  = 6'b000010;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] ANDI = 6'b001100;
    localparam logic [5:0] ORI  = 6'b001101;
    localparam logic [5:0] SLTI = 6'b001010;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode, funct;
    logic       zero, mem_ready;

    logic a_PCWrite, a_PCWriteCond, a_IorD, a_MemRead, a_MemWrite, a_IRWrite;
    logic a_RegDst, a_MemtoReg, a_RegWrite, a_ALUSrcA, a_ExtOp, a_pc_en, a_fault;
    logic [1:0] a_ALUSrcB, a_PCSource;
    logic [2:0] a_ALUControl;
    logic [3:0] a_state;

    logic b_PCWrite, b_PCWriteCond, b_IorD, b_MemRead, b_MemWrite, b_IRWrite;
    logic b_RegDst, b_MemtoReg, b_RegWrite, b_ALUSrcA, b_ExtOp, b_pc_en, b_fault;
    logic [1:0] b_ALUSrcB, b_PCSource;
    logic [2:0] b_ALUControl;
    logic [3:0] b_state;

    logic [19:0] ctl_a, ctl_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mips_mc_control dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .PCWrite(a_PCWrite), .PCWriteCond(a_PCWriteCond),
        .IorD(a_IorD), .MemRead(a_MemRead), .MemWrite(a_MemWrite), .IRWrite(a_IRWrite),
        .RegDst(a_RegDst), .MemtoReg(a_MemtoReg), .RegWrite(a_RegWrite),
        .ALUSrcA(a_ALUSrcA), .ExtOp(a_ExtOp), .ALUSrcB(a_ALUSrcB), .PCSource(a_PCSource),
        .ALUControl(a_ALUControl), .pc_en(a_pc_en), .fault(a_fault), .state(a_state)
    );

    mips_mc_control #(
        .ENABLE_IMM(0),
        .MEM_TIMEOUT(4),
        .TO_W(3)
    ) dut2 (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .PCWrite(b_PCWrite), .PCWriteCond(b_PCWriteCond),
        .IorD(b_IorD), .MemRead(b_MemRead), .MemWrite(b_MemWrite), .IRWrite(b_IRWrite),
        .RegDst(b_RegDst), .MemtoReg(b_MemtoReg), .RegWrite(b_RegWrite),
        .ALUSrcA(b_ALUSrcA), .ExtOp(b_ExtOp), .ALUSrcB(b_ALUSrcB), .PCSource(b_PCSource),
        .ALUControl(b_ALUControl), .pc_en(b_pc_en), .fault(b_fault), .state(b_state)
    );

    assign ctl_a = {a_PCWrite, a_PCWriteCond, a_IorD, a_MemRead, a_MemWrite, a_IRWrite,
                    a_RegDst, a_MemtoReg, a_RegWrite, a_ALUSrcA, a_ExtOp, a_ALUSrcB,
                    a_PCSource, a_ALUControl, a_pc_en, a_fault};
    assign ctl_b = {b_PCWrite, b_PCWriteCond, b_IorD, b_MemRead, b_MemWrite, b_IRWrite,
                    b_RegDst, b_MemtoReg, b_RegWrite, b_ALUSrcA, b_ExtOp, b_ALUSrcB,
                    b_PCSource, b_ALUControl, b_pc_en, b_fault};

    function automatic logic [19:0] ctl(
        input logic pcw, pcwc, iord, mr, mw, irw, rd, m2r, rw, asa, ext,
        input logic [1:0] asb, pcs, input logic [2:0] alu, input logic pcen, flt);
        return {pcw, pcwc, iord, mr, mw, irw, rd, m2r, rw, asa, ext, asb, pcs, alu, pcen, flt};
    endfunction

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic        rdy;
        logic [3:0]  st;
        logic [19:0] c;
    } vec_t;

    vec_t vecs[$];

    logic [19:0] c_reset, c_fetch_w, c_fetch_r, c_decode, c_memadr, c_memrd, c_memwb;
    logic [19:0] c_memwr, c_aluwb, c_jump, c_immwb, c_fault;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic pv(input logic [5:0] op, fn, input logic z, rdy,
                      input logic [3:0] st, input logic [19:0] c);
        vecs.push_back('{op, fn, z, rdy, st, c});
    endtask

    // Called at a falling edge; drives, samples mid-cycle, returns at next falling edge.
    task automatic apply(input logic [5:0] op, fn, input logic z, rdy,
                         input logic [3:0] st, input logic [19:0] c, input string nm);
        opcode = op; funct = fn; zero = z; mem_ready = rdy;
        #2;
        check({nm, "_state"}, 32'(a_state), 32'(st));
        check({nm, "_ctl"}, 32'(ctl_a), 32'(c));
        @(negedge clk);
    endtask

    task automatic bstep(input logic rdy, input logic [3:0] st, input string nm);
        mem_ready = rdy;
        #2;
        check(nm, 32'(b_state), 32'(st));
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        c_reset   = ctl(0,0,0,0,0,0,0,0,0,0,0,2'b01,2'b00,3'b010,0,0);
        c_fetch_w = ctl(0,0,0,1,0,0,0,0,0,0,0,2'b01,2'b00,3'b010,0,0);
        c_fetch_r = ctl(1,0,0,1,0,1,0,0,0,0,0,2'b01,2'b00,3'b010,1,0);
        c_decode  = ctl(0,0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010,0,0);
        c_memadr  = ctl(0,0,0,0,0,0,0,0,0,1,0,2'b10,2'b00,3'b010,0,0);
        c_memrd   = ctl(0,0,1,1,0,0,0,0,0,0,0,2'b00,2'b00,3'b010,0,0);
        c_memwb   = ctl(0,0,0,0,0,0,0,1,1,0,0,2'b00,2'b00,3'b010,0,0);
        c_memwr   = ctl(0,0,1,0,1,0,0,0,0,0,0,2'b00,2'b00,3'b010,0,0);
        c_aluwb   = ctl(0,0,0,0,0,0,1,0,1,0,0,2'b00,2'b00,3'b010,0,0);
        c_jump    = ctl(1,0,0,0,0,0,0,0,0,0,0,2'b00,2'b10,3'b010,1,0);
        c_immwb   = ctl(0,0,0,0,0,0,0,0,1,0,0,2'b00,2'b00,3'b010,0,0);
        c_fault   = ctl(0,0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,3'b010,0,1);

        // R-type: add (mem_ready low outside memory states is ignored), sub, and, or, slt
        pv(RT, 6'b100000, 0, 1, 0, c_fetch_r);
        pv(RT, 6'b100000, 0, 0, 1, c_decode);
        pv(RT, 6'b100000, 0, 0, 6, ctl(0,0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,3'b010,0,0));
        pv(RT, 6'b100000, 0, 0, 7, c_aluwb);
        pv(RT, 6'b100010, 0, 1, 0, c_fetch_r);
        pv(RT, 6'b100010, 0, 1, 1, c_decode);
        pv(RT, 6'b100010, 0, 1, 6, ctl(0,0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,3'b110,0,0));
        pv(RT, 6'b100010, 0, 1, 7, c_aluwb);
        pv(RT, 6'b100100, 0, 1, 0, c_fetch_r);
        pv(RT, 6'b100100, 0, 1, 1, c_decode);
        pv(RT, 6'b100100, 0, 1, 6, ctl(0,0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,3'b000,0,0));
        pv(RT, 6'b100100, 0, 1, 7, c_aluwb);
        pv(RT, 6'b100101, 0, 1, 0, c_fetch_r);
        pv(RT, 6'b100101, 0, 1, 1, c_decode);
        pv(RT, 6'b100101, 0, 1, 6, ctl(0,0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,3'b001,0,0));
        pv(RT, 6'b100101, 0, 1, 7, c_aluwb);
        pv(RT, 6'b101010, 0, 1, 0, c_fetch_r);
        pv(RT, 6'b101010, 0, 1, 1, c_decode);
        pv(RT, 6'b101010, 0, 1, 6, ctl(0,0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,3'b111,0,0));
        pv(RT, 6'b101010, 0, 1, 7, c_aluwb);
        // lw: 3 fetch waits, 2 read waits -> 10 cycles, IRWrite once
        pv(LW, 0, 0, 0, 0, c_fetch_w);
        pv(LW, 0, 0, 0, 0, c_fetch_w);
        pv(LW, 0, 0, 0, 0, c_fetch_w);
        pv(LW, 0, 0, 1, 0, c_fetch_r);
        pv(LW, 0, 0, 1, 1, c_decode);
        pv(LW, 0, 0, 1, 2, c_memadr);
        pv(LW, 0, 0, 0, 3, c_memrd);
        pv(LW, 0, 0, 0, 3, c_memrd);
        pv(LW, 0, 0, 1, 3, c_memrd);
        pv(LW, 0, 0, 1, 4, c_memwb);
        // sw
        pv(SW, 0, 0, 1, 0, c_fetch_r);
        pv(SW, 0, 0, 1, 1, c_decode);
        pv(SW, 0, 0, 1, 2, c_memadr);
        pv(SW, 0, 0, 1, 5, c_memwr);
        // branches
        pv(BEQ, 0, 1, 1, 0, c_fetch_r);
        pv(BEQ, 0, 1, 1, 1, c_decode);
        pv(BEQ, 0, 1, 1, 8, ctl(0,1,0,0,0,0,0,0,0,1,0,2'b00,2'b01,3'b110,1,0));
        pv(BEQ, 0, 0, 1, 0, c_fetch_r);
        pv(BEQ, 0, 0, 1, 1, c_decode);
        pv(BEQ, 0, 0, 1, 8, ctl(0,1,0,0,0,0,0,0,0,1,0,2'b00,2'b01,3'b110,0,0));
        pv(BNE, 0, 1, 1, 0, c_fetch_r);
        pv(BNE, 0, 1, 1, 1, c_decode);
        pv(BNE, 0, 1, 1, 8, ctl(0,1,0,0,0,0,0,0,0,1,0,2'b00,2'b01,3'b110,0,0));
        pv(BNE, 0, 0, 1, 0, c_fetch_r);
        pv(BNE, 0, 0, 1, 1, c_decode);
        pv(BNE, 0, 0, 1, 8, ctl(0,1,0,0,0,0,0,0,0,1,0,2'b00,2'b01,3'b110,1,0));
        // jump
        pv(JMP, 0, 0, 1, 0, c_fetch_r);
        pv(JMP, 0, 0, 1, 1, c_decode);
        pv(JMP, 0, 0, 1, 9, c_jump);
        // immediates
        pv(ORI, 0, 0, 1, 0, c_fetch_r);
        pv(ORI, 0, 0, 1, 1, c_decode);
        pv(ORI, 0, 0, 1, 10, ctl(0,0,0,0,0,0,0,0,0,1,1,2'b10,2'b00,3'b001,0,0));
        pv(ORI, 0, 0, 1, 11, c_immwb);
        pv(ADDI, 0, 0, 1, 0, c_fetch_r);
        pv(ADDI, 0, 0, 1, 1, c_decode);
        pv(ADDI, 0, 0, 1, 10, ctl(0,0,0,0,0,0,0,0,0,1,0,2'b10,2'b00,3'b010,0,0));
        pv(ADDI, 0, 0, 1, 11, c_immwb);
        pv(ANDI, 0, 0, 1, 0, c_fetch_r);
        pv(ANDI, 0, 0, 1, 1, c_decode);
        pv(ANDI, 0, 0, 1, 10, ctl(0,0,0,0,0,0,0,0,0,1,1,2'b10,2'b00,3'b000,0,0));
        pv(ANDI, 0, 0, 1, 11, c_immwb);
        pv(SLTI, 0, 0, 1, 0, c_fetch_r);
        pv(SLTI, 0, 0, 1, 1, c_decode);
        pv(SLTI, 0, 0, 1, 10, ctl(0,0,0,0,0,0,0,0,0,1,0,2'b10,2'b00,3'b111,0,0));
        pv(SLTI, 0, 0, 1, 11, c_immwb);

        // Reset state: strobes forced low even with mem_ready high
        reset = 1'b0; opcode = RT; funct = 6'b100000; zero = 1'b0; mem_ready = 1'b1;
        #2;
        check("reset_state", 32'(a_state), 32'd0);
        check("reset_ctl", 32'(ctl_a), 32'(c_reset));
        check("reset_state_b", 32'(b_state), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].op, vecs[i].fn, vecs[i].z, vecs[i].rdy, vecs[i].st, vecs[i].c,
                  $sformatf("vec%0d", i));
        end

        // Asynchronous reset in the middle of a data read
        apply(LW, 0, 0, 1, 0, c_fetch_r, "rst_fetch");
        apply(LW, 0, 0, 1, 1, c_decode, "rst_decode");
        apply(LW, 0, 0, 1, 2, c_memadr, "rst_memadr");
        mem_ready = 1'b0;
        #2;
        check("rst_memrd_state", 32'(a_state), 32'd3);
        mem_ready = 1'b1;
        #1;
        reset = 1'b0;
        #1;
        check("rst_async_state", 32'(a_state), 32'd0);
        check("rst_async_ctl", 32'(ctl_a), 32'(c_reset));
        @(negedge clk);
        reset = 1'b1;

        // Watchdog: MEM_TIMEOUT=4 instance faults on the 4th wait edge in MEMWR
        apply(SW, 0, 0, 1, 0, c_fetch_r, "wd_fetch");
        apply(SW, 0, 0, 1, 1, c_decode, "wd_decode");
        apply(SW, 0, 0, 1, 2, c_memadr, "wd_memadr");
        for (int k = 0; k < 4; k++) begin
            bstep(1'b0, 4'd5, $sformatf("wd_wait%0d_b", k));
        end
        #2;
        check("wd_fault_state_b", 32'(b_state), 32'd15);
        check("wd_fault_ctl_b", 32'(ctl_b), 32'(c_fault));
        check("wd_long_state_a", 32'(a_state), 32'd5);
        check("wd_long_ctl_a", 32'(ctl_a), 32'(c_memwr));
        mem_ready = 1'b1;
        @(negedge clk);
        #2;
        check("wd_sticky_b", 32'(b_state), 32'd15);
        check("wd_done_a", 32'(a_state), 32'd0);
        @(negedge clk);
        do_reset();
        #2;
        check("wd_cleared_b", 32'(b_state), 32'd0);
        check("wd_cleared_fault_b", 32'(b_fault), 32'd0);
        @(negedge clk);
        do_reset();

        // Ready on the limit cycle completes the access (fetch and data read)
        opcode = LW;
        for (int k = 0; k < 3; k++) bstep(1'b0, 4'd0, $sformatf("lim_fw%0d_b", k));
        bstep(1'b1, 4'd0, "lim_fetch_b");
        bstep(1'b1, 4'd1, "lim_decode_b");
        bstep(1'b1, 4'd2, "lim_memadr_b");
        for (int k = 0; k < 3; k++) bstep(1'b0, 4'd3, $sformatf("lim_rw%0d_b", k));
        bstep(1'b1, 4'd3, "lim_memrd_b");
        bstep(1'b1, 4'd4, "lim_memwb_b");
        bstep(1'b1, 4'd0, "lim_back_b");
        do_reset();

        // Immediate opcode with ENABLE_IMM=0 faults after DECODE
        opcode = ADDI;
        bstep(1'b1, 4'd0, "noimm_fetch_b");
        bstep(1'b1, 4'd1, "noimm_decode_b");
        #2;
        check("noimm_fault_b", 32'(b_state), 32'd15);
        check("noimm_fault_flag_b", 32'(b_fault), 32'd1);
        check("imm_ok_a", 32'(a_state), 32'd10);
        @(negedge clk);
        do_reset();

        // pc_en follows zero combinationally inside BRANCH
        apply(BEQ, 0, 1, 1, 0, c_fetch_r, "bz_fetch");
        apply(BEQ, 0, 1, 1, 1, c_decode, "bz_decode");
        zero = 1'b1;
        #2;
        check("bz_pcen_hi", 32'(a_pc_en), 32'd1);
        zero = 1'b0;
        #1;
        check("bz_pcen_lo", 32'(a_pc_en), 32'd0);
        @(negedge clk);

        // Illegal funct faults from RTYPE_EX
        apply(RT, 6'b000111, 0, 1, 0, c_fetch_r, "badfn_fetch");
        apply(RT, 6'b000111, 0, 1, 1, c_decode, "badfn_decode");
        #2;
        check("badfn_rtype_state", 32'(a_state), 32'd6);
        @(negedge clk);
        apply(RT, 6'b000111, 0, 1, 15, c_fault, "badfn_fault");
        apply(RT, 6'b100000, 0, 1, 15, c_fault, "badfn_sticky");
        do_reset();

        // Unknown opcode faults after DECODE
        apply(6'b111111, 0, 0, 1, 0, c_fetch_r, "badop_fetch");
        apply(6'b111111, 0, 0, 1, 1, c_decode, "badop_decode");
        apply(6'b111111, 0, 0, 1, 15, c_fault, "badop_fault");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_mc_control.md
# mips_mc_control

Parametrised multi-cycle MIPS control unit, successor to the fixed control FSM in the multi-cycle core. It adds four things the earlier control lacks:
- a `mem_ready` handshake, so instruction and data memory may take any number of cycles;
- a watchdog that moves the FSM to a sticky fault state when memory stops answering;
- optional I-type ALU instructions (addi/andi/ori/slti) and bne;
- a single combined `pc_en` output.

It sits between the instruction register/ALU flags and the datapath and memory strobes.

## Interface
Parameters:
- `ENABLE_IMM`, 1: 1 decodes addi/andi/ori/slti; 0 treats those opcodes as illegal.
- `MEM_TIMEOUT`, 16: wait-cycle limit in memory states; 0 disables the watchdog.
- `TO_W`, 5: watchdog counter width; must satisfy `MEM_TIMEOUT < 2**TO_W`.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `opcode`  in  6  IR[31:26].
- `funct`  in  6  IR[5:0].
- `zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `PCWrite`, `PCWriteCond`, `IorD`, `MemRead`, `MemWrite`, `IRWrite`, `RegDst`, `MemtoReg`, `RegWrite`, `ALUSrcA`  out  1 each  datapath controls.
- `ExtOp`  out  1  1 = zero-extend the immediate.
- `ALUSrcB`  out  2  00 B, 01 constant 4, 10 ext imm, 11 ext imm<<2.
- `PCSource`  out  2  00 ALU, 01 ALUOut, 10 jump target.
- `ALUControl`  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt.
- `pc_en`  out  1  PC load = PCWrite | (PCWriteCond & (zero ^ branch_ne)).
- `fault`  out  1  sticky; set on illegal opcode or watchdog expiry.
- `state`  out  4  current state code, for debug.

## Operation
- Moore FSM on a 4-bit state register; outputs decode from state, plus `mem_ready` gating and `zero` for `pc_en`.
- States: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPE_EX 6, ALUWB 7, BRANCH 8, JUMP 9, IMM_EX 10, IMM_WB 11, FAULT 15.
- FETCH:
  - asserts MemRead, IorD=0, ALUSrcA=0, ALUSrcB=01, add, PCSource=00.
  - IRWrite and PCWrite are high only while `mem_ready`=1.
  - Moves to DECODE on `mem_ready`, otherwise holds.
- DECODE: ALUSrcA=0, ALUSrcB=11, add. Next state by opcode:
  - 000000 → RTYPE_EX.
  - 100011 or 101011 → MEMADR.
  - 000100 or 000101 → BRANCH.
  - 000010 → JUMP.
  - 001000, 001100, 001101, 001010 → IMM_EX if `ENABLE_IMM`, else FAULT.
  - any other opcode → FAULT.
- MEMADR: ALUSrcA=1, ALUSrcB=10, add; next MEMRD for lw, MEMWR for sw.
- MEMRD: MemRead, IorD=1; moves to MEMWB on `mem_ready`, else holds.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1; next FETCH.
- MEMWR: MemWrite, IorD=1; moves to FETCH on `mem_ready`, else holds.
- RTYPE_EX: ALUSrcA=1, ALUSrcB=00. ALUControl from `funct`:
  - 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
  - any other funct → FAULT on the next edge.
- ALUWB: RegDst=1, MemtoReg=0, RegWrite=1; next FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, sub, PCSource=01, PCWriteCond=1; `branch_ne` = (opcode==000101). Next FETCH.
- JUMP: PCSource=10, PCWrite=1; next FETCH.
- IMM_EX: ALUSrcA=1, ALUSrcB=10.
  - addi: add, ExtOp=0. slti: slt, ExtOp=0.
  - andi: and, ExtOp=1. ori: or, ExtOp=1.
- IMM_WB: RegDst=0, MemtoReg=0, RegWrite=1; next FETCH.
- FAULT: all strobes 0; `fault`=1; exits only via reset.
- Unlisted outputs in each state: strobes 0, selects 0, ALUControl 010.
- Watchdog:
  - Counter clears on entry to FETCH, MEMRD or MEMWR, and increments each non-ready cycle in those states.
  - When it reaches `MEM_TIMEOUT`-1 while `mem_ready`=0, the next state is FAULT.
  - `mem_ready`=1 on the limit cycle wins: the access completes normally.

## Timing
- Reset low:
  - state=FETCH, counter=0, `fault`=0.
  - All strobes and `pc_en` are forced 0 combinationally; selects show FETCH values.
- First fetch begins in the first cycle after reset deasserts.
- Latencies with `mem_ready` tied high: lw 5, sw 4, R-type 4, I-type 4, beq/bne 3, j 3 cycles.
- Each memory wait cycle adds 1 cycle.
- `pc_en` is combinational from `zero` within BRANCH.
- A `mem_ready` pulse outside FETCH/MEMRD/MEMWR is ignored.
- Reset mid-access aborts immediately; no partial write is reported.

## Structure
- Shared package `mips_mc_pkg` holds:
  - opcode and funct constants;
  - the state encoding;
  - ALUControl, ALUSrcB and PCSource codes.
- One sub-module, `mips_alu_decoder`: a combinational funct/opcode → ALUControl/ExtOp/illegal mapping, reused by RTYPE_EX and IMM_EX.

## Test plan
- Reset low then release, `mem_ready`=1, opcode add (000000/100000) → states 0,1,6,7,0; RegWrite=1 only in ALUWB; total 4 cycles.
- lw with `mem_ready` low for 3 cycles in FETCH and 2 in MEMRD → 10 cycles; IRWrite high exactly one cycle.
- beq with zero=1 → `pc_en`=1 in BRANCH; bne with zero=1 → `pc_en`=0; bne with zero=0 → `pc_en`=1.
- MEM_TIMEOUT=4, `mem_ready` held low in MEMWR → FAULT on the 4th wait edge, `fault`=1, MemWrite=0 afterwards; cleared only by reset.
- ENABLE_IMM=0 with opcode 001000 → FAULT after DECODE. ENABLE_IMM=1 with ori → ExtOp=1 and ALUControl=001 in IMM_EX.
- Funct 000111 in RTYPE_EX → FAULT; reset asserted mid-MEMRD → state=0 and all strobes 0 asynchronously.
